id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-002 SHALL have ports: id_valid in 1, decode presents instruction; id_ready out 1, stage accepts this cycle.
REQ-003 SHALL have ports: id_rs1, id_rs2, id_rd in 5 each; id_rs1_data, id_rs2_data, id_imm in 32 each; id_use_imm in 1; id_alu_control in 4; id_equal_comp in 2; id_reg_write, id_mem_read in 1 each.
REQ-004 SHALL have ports: fwd_ex_rd in 5, fwd_ex_reg_write in 1, fwd_ex_result in 32 (ALU result of EX instruction); fwd_mem_rd in 5, fwd_mem_reg_write in 1, fwd_mem_result in 32.
REQ-005 SHALL have ports: ex_stall in 1, downstream hold; flush in 1, squash.
REQ-006 SHALL have ports: ex_valid out 1; ScrA, ScrB out 32; alu_control out 4; equalComp out 2; ex_rd out 5; ex_reg_write, ex_mem_read out 1.
REQ-007 One clock; reset is synchronous and active-high (clk, rst).

Function
REQ-008 States SHALL be EMPTY, FULL, BUBBLE; ex_valid SHALL be 1 only in FULL.
REQ-009 load_use SHALL be 1 when ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | (ex_rd==id_rs2 & !id_use_imm)) & id_valid.
REQ-010 id_ready SHALL equal flush | (!ex_stall & !load_use), combinationally.
REQ-011 Capture SHALL occur when id_valid & id_ready & !flush & !load_use: all ex_* outputs load next edge, state->FULL; latency one cycle.
REQ-012 No capture, !ex_stall, !flush: load_use SHALL go to BUBBLE, otherwise EMPTY; BUBBLE lasts exactly one cycle.
REQ-013 ex_stall=1 and flush=0 SHALL hold state and every output unchanged.
REQ-014 flush SHALL override ex_stall and load_use: next state EMPTY, ex_valid=0, ex_reg_write=0, ex_mem_read=0.
REQ-015 Operand A SHALL select fwd_ex_result if fwd_ex_reg_write & fwd_ex_rd==id_rs1 & id_rs1!=0, else fwd_mem_result under same rule for mem, else id_rs1_data.
REQ-016 Operand B SHALL be id_imm when id_use_imm, else forwarded per REQ-015 using id_rs2.
REQ-017 Register x0 SHALL never be forwarded; EX source SHALL beat MEM source when both match.
REQ-018 Bubble/empty cycles SHALL drive ex_reg_write=0, ex_mem_read=0; ScrA/ScrB keep last values.

Reset
REQ-019 rst SHALL force state EMPTY and all outputs 0 (ScrA, ScrB, alu_control, equalComp, ex_rd, ex_valid, ex_reg_write, ex_mem_read) next edge.
REQ-020 rst SHALL override flush, ex_stall and capture, including mid-bubble.
REQ-021 id_ready during rst SHALL be 0.

Configuration
REQ-022 Macro ID_EX_PERF_EN defined: SHALL add output stall_cycles out 32, counting cycles with load_use=1 or ex_stall=1, reset to 0, wrapping 0xFFFFFFFF->0.
REQ-023 Macro undefined: stall_cycles port and counter SHALL be absent; other behaviour identical.

Verification
REQ-024 rst 1 cycle, id_valid=1 -> all outputs 0, id_ready=0 during rst, state EMPTY after.
REQ-025 Capture ADD rs1=5 data 0x10, rs2=6 data 0x20, no forward -> next cycle ex_valid=1, ScrA=0x10, ScrB=0x20, alu_control=0010.
REQ-026 id_rs1=3, fwd_ex_rd=3 result 0xAA, fwd_mem_rd=3 result 0xBB, both write -> ScrA=0xAA; repeat with rs1=0 -> ScrA=id_rs1_data.
REQ-027 EX holds load rd=7, ID rs2=7 use_imm=0 -> id_ready=0 one cycle, ex_valid=0 next, then capture; with use_imm=1 -> no bubble.
REQ-028 FULL with ex_stall=1 and flush=1 same cycle -> next ex_valid=0, ex_reg_write=0.
REQ-029 ID_EX_PERF_EN: 3 stall cycles + 1 bubble -> stall_cycles=4; preload 0xFFFFFFFF, one stall -> 0.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Bundle of decode, forwarding, control and EX-side signals between ID and EX.
// ID_EX_PERF_EN adds the stall_cycles counter output.
interface id_ex_stage_if;
   logic        id_valid;
   logic        id_ready;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [4:0]  id_rd;
   logic [31:0] id_rs1_data;
   logic [31:0] id_rs2_data;
   logic [31:0] id_imm;
   logic        id_use_imm;
   logic [3:0]  id_alu_control;
   logic [1:0]  id_equal_comp;
   logic        id_reg_write;
   logic        id_mem_read;
   logic [4:0]  fwd_ex_rd;
   logic        fwd_ex_reg_write;
   logic [31:0] fwd_ex_result;
   logic [4:0]  fwd_mem_rd;
   logic        fwd_mem_reg_write;
   logic [31:0] fwd_mem_result;
   logic        ex_stall;
   logic        flush;
   logic        ex_valid;
   logic [31:0] ScrA;
   logic [31:0] ScrB;
   logic [3:0]  alu_control;
   logic [1:0]  equalComp;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        ex_mem_read;
`ifdef ID_EX_PERF_EN
   logic [31:0] stall_cycles;
`endif

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
             id_use_imm, id_alu_control, id_equal_comp, id_reg_write, id_mem_read,
             fwd_ex_rd, fwd_ex_reg_write, fwd_ex_result,
             fwd_mem_rd, fwd_mem_reg_write, fwd_mem_result, ex_stall, flush,
      output id_ready, ex_valid, ScrA, ScrB, alu_control, equalComp, ex_rd,
             ex_reg_write, ex_mem_read
`ifdef ID_EX_PERF_EN
      , output stall_cycles
`endif
   );

   modport master (
      output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
             id_use_imm, id_alu_control, id_equal_comp, id_reg_write, id_mem_read,
             fwd_ex_rd, fwd_ex_reg_write, fwd_ex_result,
             fwd_mem_rd, fwd_mem_reg_write, fwd_mem_result, ex_stall, flush,
      input  id_ready, ex_valid, ScrA, ScrB, alu_control, equalComp, ex_rd,
             ex_reg_write, ex_mem_read
`ifdef ID_EX_PERF_EN
      , input stall_cycles
`endif
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubble insertion.
// Define ID_EX_PERF_EN to add a 32-bit stall_cycles performance counter.
//
// state  | meaning
// EMPTY  | no instruction held in EX
// FULL   | valid instruction held, ex_valid=1
// BUBBLE | one-cycle bubble inserted for a load-use hazard
module id_ex_stage (
   input logic         clk,
   input logic         rst,
   id_ex_stage_if.slave bus
);
   typedef enum logic [1:0] {EMPTY, FULL, BUBBLE} state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic        w_load_use;
   logic        w_id_ready;
   logic        w_capture;
   logic [31:0] w_op_a;
   logic [31:0] w_op_b;

   logic [31:0] r_scr_a;
   logic [31:0] r_scr_b;
   logic [3:0]  r_alu_control;
   logic [1:0]  r_equal_comp;
   logic [4:0]  r_rd;
   logic        r_reg_write;
   logic        r_mem_read;

   always_ff @(posedge clk) begin
      if (rst) r_state <= EMPTY;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_load_use   = 1'b0;
      w_id_ready   = 1'b0;
      w_capture    = 1'b0;
      w_next_state = r_state;

      w_load_use = (r_state == FULL) & r_mem_read & (r_rd != 5'd0) &
                   ((r_rd == bus.id_rs1) | ((r_rd == bus.id_rs2) & !bus.id_use_imm)) &
                   bus.id_valid;
      w_id_ready = !rst & (bus.flush | (!bus.ex_stall & !w_load_use));
      w_capture  = bus.id_valid & w_id_ready & !bus.flush & !w_load_use;

      if (bus.flush)          w_next_state = EMPTY;
      else if (bus.ex_stall)  w_next_state = r_state;
      else if (w_capture)     w_next_state = FULL;
      else if (w_load_use)    w_next_state = BUBBLE;
      else                    w_next_state = EMPTY;
   end

   // EX result beats MEM result; x0 is never forwarded
   always_comb begin
      w_op_a = bus.id_rs1_data;
      w_op_b = bus.id_rs2_data;

      if (bus.fwd_ex_reg_write && bus.fwd_ex_rd == bus.id_rs1 && bus.id_rs1 != 5'd0)
         w_op_a = bus.fwd_ex_result;
      else if (bus.fwd_mem_reg_write && bus.fwd_mem_rd == bus.id_rs1 && bus.id_rs1 != 5'd0)
         w_op_a = bus.fwd_mem_result;

      if (bus.id_use_imm)
         w_op_b = bus.id_imm;
      else if (bus.fwd_ex_reg_write && bus.fwd_ex_rd == bus.id_rs2 && bus.id_rs2 != 5'd0)
         w_op_b = bus.fwd_ex_result;
      else if (bus.fwd_mem_reg_write && bus.fwd_mem_rd == bus.id_rs2 && bus.id_rs2 != 5'd0)
         w_op_b = bus.fwd_mem_result;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_scr_a       <= 32'd0;
         r_scr_b       <= 32'd0;
         r_alu_control <= 4'd0;
         r_equal_comp  <= 2'd0;
         r_rd          <= 5'd0;
         r_reg_write   <= 1'b0;
         r_mem_read    <= 1'b0;
      end else if (bus.flush) begin
         r_reg_write <= 1'b0;
         r_mem_read  <= 1'b0;
      end else if (bus.ex_stall) begin
         r_reg_write <= r_reg_write;
      end else if (w_capture) begin
         r_scr_a       <= w_op_a;
         r_scr_b       <= w_op_b;
         r_alu_control <= bus.id_alu_control;
         r_equal_comp  <= bus.id_equal_comp;
         r_rd          <= bus.id_rd;
         r_reg_write   <= bus.id_reg_write;
         r_mem_read    <= bus.id_mem_read;
      end else begin
         // bubble or empty: side effects off, operands keep last values
         r_reg_write <= 1'b0;
         r_mem_read  <= 1'b0;
      end
   end

   assign bus.id_ready     = w_id_ready;
   assign bus.ex_valid     = (r_state == FULL);
   assign bus.ScrA         = r_scr_a;
   assign bus.ScrB         = r_scr_b;
   assign bus.alu_control  = r_alu_control;
   assign bus.equalComp    = r_equal_comp;
   assign bus.ex_rd        = r_rd;
   assign bus.ex_reg_write = r_reg_write;
   assign bus.ex_mem_read  = r_mem_read;

`ifdef ID_EX_PERF_EN
   logic [31:0] r_stall_cycles;

   always_ff @(posedge clk) begin
      if (rst)
         r_stall_cycles <= 32'd0;
      else if (w_load_use | bus.ex_stall)
         r_stall_cycles <= r_stall_cycles + 32'd1;
   end

   assign bus.stall_cycles = r_stall_cycles;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver pushes expected EX contents per accepted
// instruction, monitor pops and compares after each observed handshake.
module tb_id_ex_stage;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   id_ex_stage_if bus();
   id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  alu;
      logic [1:0]  eq;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
   } exp_t;

   exp_t sb[$];
   int   nvec = 0;
   int   nmis = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      nvec++;
      if (act !== expv) begin
         nmis++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
      bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0; bus.id_use_imm = 0;
      bus.id_alu_control = 0; bus.id_equal_comp = 0; bus.id_reg_write = 0; bus.id_mem_read = 0;
      bus.fwd_ex_rd = 0; bus.fwd_ex_reg_write = 0; bus.fwd_ex_result = 0;
      bus.fwd_mem_rd = 0; bus.fwd_mem_reg_write = 0; bus.fwd_mem_result = 0;
      bus.ex_stall = 0; bus.flush = 0;
   endtask

   task automatic issue(input logic [4:0] rs1, input logic [31:0] d1,
                        input logic [4:0] rs2, input logic [31:0] d2,
                        input logic [31:0] imm, input logic ui,
                        input logic [3:0] alu, input logic [1:0] eq,
                        input logic [4:0] rd, input logic rw, input logic mr);
      bus.id_valid = 1; bus.id_rs1 = rs1; bus.id_rs1_data = d1;
      bus.id_rs2 = rs2; bus.id_rs2_data = d2; bus.id_imm = imm; bus.id_use_imm = ui;
      bus.id_alu_control = alu; bus.id_equal_comp = eq; bus.id_rd = rd;
      bus.id_reg_write = rw; bus.id_mem_read = mr;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] alu,
                       input logic [1:0] eq, input logic [4:0] rd, input logic rw, input logic mr);
      exp_t e;
      e.a = a; e.b = b; e.alu = alu; e.eq = eq; e.rd = rd; e.rw = rw; e.mr = mr;
      sb.push_back(e);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_ScrA"}, bus.ScrA, 0);
      chk({nm, "_ScrB"}, bus.ScrB, 0);
      chk({nm, "_ctl"}, {19'd0, bus.alu_control, bus.equalComp, bus.ex_rd,
                         bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read}, 0);
   endtask

   // monitor
   initial begin
      logic hs;
      exp_t e;
      forever begin
         @(negedge clk);
         hs = bus.id_valid & bus.id_ready & !bus.flush & !rst;
         @(posedge clk);
         #2;
         if (hs) begin
            if (sb.size() == 0) begin
               chk("unexpected_capture", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("mon_ex_valid", 32'(bus.ex_valid), 1);
               chk("mon_ScrA", bus.ScrA, e.a);
               chk("mon_ScrB", bus.ScrB, e.b);
               chk("mon_alu", 32'(bus.alu_control), 32'(e.alu));
               chk("mon_eq", 32'(bus.equalComp), 32'(e.eq));
               chk("mon_rd", 32'(bus.ex_rd), 32'(e.rd));
               chk("mon_rw", 32'(bus.ex_reg_write), 32'(e.rw));
               chk("mon_mr", 32'(bus.ex_mem_read), 32'(e.mr));
            end
         end
      end
   end

   initial begin
      idle();
      rst = 1;
      issue(5'd5, 32'h10, 5'd6, 32'h20, 0, 0, 4'b0010, 2'b00, 5'd1, 1, 0);
      #1 chk("rst_id_ready", 32'(bus.id_ready), 0);
      tick();
      chk_zero("reset");
      rst = 0;

      // ADD capture, no forwarding
      issue(5'd5, 32'h10, 5'd6, 32'h20, 0, 0, 4'b0010, 2'b00, 5'd1, 1, 0);
      push(32'h10, 32'h20, 4'b0010, 2'b00, 5'd1, 1, 0);
      tick();
      idle();
      tick();
      chk("empty_ex_valid", 32'(bus.ex_valid), 0);
      chk("empty_reg_write", 32'(bus.ex_reg_write), 0);
      chk("empty_ScrA_kept", bus.ScrA, 32'h10);

      // forwarding: EX beats MEM
      bus.fwd_ex_rd = 3; bus.fwd_ex_reg_write = 1; bus.fwd_ex_result = 32'hAA;
      bus.fwd_mem_rd = 3; bus.fwd_mem_reg_write = 1; bus.fwd_mem_result = 32'hBB;
      issue(5'd3, 32'h33, 5'd4, 32'h44, 0, 0, 4'b0110, 2'b01, 5'd2, 1, 0);
      push(32'hAA, 32'h44, 4'b0110, 2'b01, 5'd2, 1, 0);
      tick();
      // x0 never forwarded
      bus.fwd_ex_rd = 0; bus.fwd_mem_rd = 0;
      issue(5'd0, 32'h55, 5'd0, 32'h66, 0, 0, 4'b0001, 2'b00, 5'd3, 1, 0);
      push(32'h55, 32'h66, 4'b0001, 2'b00, 5'd3, 1, 0);
      tick();
      // MEM to A, EX to B
      bus.fwd_ex_rd = 8; bus.fwd_mem_rd = 9;
      issue(5'd9, 32'h11, 5'd8, 32'h22, 0, 0, 4'b0011, 2'b11, 5'd4, 0, 0);
      push(32'hBB, 32'hAA, 4'b0011, 2'b11, 5'd4, 0, 0);
      tick();
      // EX not writing -> MEM used on both
      bus.fwd_ex_rd = 9; bus.fwd_ex_reg_write = 0;
      issue(5'd9, 32'h11, 5'd9, 32'h22, 0, 0, 4'b0100, 2'b10, 5'd5, 1, 0);
      push(32'hBB, 32'hBB, 4'b0100, 2'b10, 5'd5, 1, 0);
      tick();
      // immediate beats forwarding on B
      bus.fwd_ex_reg_write = 1;
      issue(5'd1, 32'h77, 5'd9, 32'h22, 32'h123, 1, 4'b0000, 2'b00, 5'd6, 1, 0);
      push(32'h77, 32'h123, 4'b0000, 2'b00, 5'd6, 1, 0);
      tick();
      idle();
      tick();

      // load-use on rs2 -> one bubble
      issue(5'd1, 32'h100, 5'd2, 32'h200, 32'h8, 1, 4'b0000, 2'b00, 5'd7, 1, 1);
      push(32'h100, 32'h8, 4'b0000, 2'b00, 5'd7, 1, 1);
      tick();
      issue(5'd2, 32'h300, 5'd7, 32'h400, 0, 0, 4'b0010, 2'b00, 5'd10, 1, 0);
      push(32'h300, 32'h400, 4'b0010, 2'b00, 5'd10, 1, 0);
      #1 chk("lu_id_ready", 32'(bus.id_ready), 0);
      tick();
      chk("bubble_ex_valid", 32'(bus.ex_valid), 0);
      chk("bubble_mem_read", 32'(bus.ex_mem_read), 0);
      chk("bubble_reg_write", 32'(bus.ex_reg_write), 0);
      chk("bubble_ScrB_kept", bus.ScrB, 32'h8);
      chk("bubble_id_ready", 32'(bus.id_ready), 1);
      tick();

      // rs2 match with use_imm -> no bubble
      issue(5'd1, 32'h100, 5'd2, 32'h200, 32'h8, 1, 4'b0000, 2'b00, 5'd7, 1, 1);
      push(32'h100, 32'h8, 4'b0000, 2'b00, 5'd7, 1, 1);
      tick();
      issue(5'd2, 32'h300, 5'd7, 32'h400, 32'h4, 1, 4'b0010, 2'b00, 5'd11, 1, 0);
      push(32'h300, 32'h4, 4'b0010, 2'b00, 5'd11, 1, 0);
      #1 chk("imm_id_ready", 32'(bus.id_ready), 1);
      tick();
      chk("imm_no_bubble", 32'(bus.ex_valid), 1);

      // load-use on rs1
      issue(5'd1, 32'h100, 5'd2, 32'h200, 32'h8, 1, 4'b0000, 2'b00, 5'd7, 1, 1);
      push(32'h100, 32'h8, 4'b0000, 2'b00, 5'd7, 1, 1);
      tick();
      issue(5'd7, 32'h500, 5'd3, 32'h600, 32'h1, 1, 4'b0010, 2'b00, 5'd13, 1, 0);
      push(32'h500, 32'h1, 4'b0010, 2'b00, 5'd13, 1, 0);
      #1 chk("lu_rs1_id_ready", 32'(bus.id_ready), 0);
      tick();
      chk("lu_rs1_bubble", 32'(bus.ex_valid), 0);
      tick();

      // stall holds everything
      issue(5'd4, 32'hABC, 5'd5, 32'hDEF, 0, 0, 4'b0111, 2'b10, 5'd12, 1, 0);
      push(32'hABC, 32'hDEF, 4'b0111, 2'b10, 5'd12, 1, 0);
      tick();
      bus.ex_stall = 1;
      issue(5'd6, 32'h999, 5'd7, 32'h888, 0, 0, 4'b1000, 2'b01, 5'd14, 1, 1);
      #1 chk("stall_id_ready", 32'(bus.id_ready), 0);
      tick();
      tick();
      chk("stall_ex_valid", 32'(bus.ex_valid), 1);
      chk("stall_ScrA", bus.ScrA, 32'hABC);
      chk("stall_ScrB", bus.ScrB, 32'hDEF);
      chk("stall_ctl", {bus.alu_control, bus.equalComp, bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read},
          {4'b0111, 2'b10, 5'd12, 1'b1, 1'b0});

      // flush overrides stall
      bus.flush = 1;
      #1 chk("flush_id_ready", 32'(bus.id_ready), 1);
      tick();
      chk("flush_ex_valid", 32'(bus.ex_valid), 0);
      chk("flush_reg_write", 32'(bus.ex_reg_write), 0);
      chk("flush_mem_read", 32'(bus.ex_mem_read), 0);
      idle();

      // reset during bubble
      issue(5'd1, 32'h100, 5'd2, 32'h200, 32'h8, 1, 4'b0000, 2'b00, 5'd7, 1, 1);
      push(32'h100, 32'h8, 4'b0000, 2'b00, 5'd7, 1, 1);
      tick();
      issue(5'd2, 32'h300, 5'd7, 32'h400, 0, 0, 4'b0010, 2'b00, 5'd10, 1, 0);
      tick();
      chk("pre_rst_bubble", 32'(bus.ex_valid), 0);
      rst = 1;
      #1 chk("rst_bubble_id_ready", 32'(bus.id_ready), 0);
      tick();
      chk_zero("rst_bubble");
      rst = 0;
      idle();
      tick();
      chk("post_rst_ex_valid", 32'(bus.ex_valid), 0);

`ifdef ID_EX_PERF_EN
      chk("perf_reset", bus.stall_cycles, 0);
      bus.ex_stall = 1;
      tick(); tick(); tick();
      bus.ex_stall = 0;
      issue(5'd1, 32'h100, 5'd2, 32'h200, 32'h8, 1, 4'b0000, 2'b00, 5'd7, 1, 1);
      push(32'h100, 32'h8, 4'b0000, 2'b00, 5'd7, 1, 1);
      tick();
      issue(5'd2, 32'h300, 5'd7, 32'h400, 0, 0, 4'b0010, 2'b00, 5'd10, 1, 0);
      push(32'h300, 32'h400, 4'b0010, 2'b00, 5'd10, 1, 0);
      tick();
      tick();
      idle();
      chk("perf_count4", bus.stall_cycles, 4);
      @(negedge clk);
      dut.r_stall_cycles = 32'hFFFF_FFFF;
      bus.ex_stall = 1;
      @(posedge clk);
      #1 bus.ex_stall = 0;
      chk("perf_wrap", bus.stall_cycles, 0);
`endif

      idle();
      tick(); tick(); tick();
      chk("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
